// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared pipeline-control types and decode constants
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ERR} mem_state_t;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between EX destination and ID sources
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [1:0] result_src_i,
  input  logic [4:0] rd_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  output logic       load_use_o
);
  assign load_use_o = result_src_i == RESULT_SRC_LOAD && rd_i != 5'd0 && (rd_i == rs1_i || rd_i == rs2_i);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer with memory-wait FSM, timeout flag and stall counter
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             MemReqValid,
  input  logic [1:0]       ResultSrcE,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCycles
);
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
  mem_state_t state_q, state_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic timeout_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic load_use, freeze, lu, br, hang;
  hazard_detect u_hazard (
    .result_src_i(ResultSrcE),
    .rd_i        (rdE),
    .rs1_i       (rs1D),
    .rs2_i       (rs2D),
    .load_use_o  (load_use)
  );
  // A miss seen in IDLE freezes immediately so the MEM instruction is never lost
  always_comb begin
    freeze      = state_q != IDLE || (MemReqM && !MemReadyM);
    br          = !freeze && PCSrcE;
    lu          = !freeze && load_use && !PCSrcE;
    hang        = state_q == WAIT && !MemReadyM && tcnt_q == LAST;
    state_d     = state_q == IDLE ? (MemReqM && !MemReadyM ? WAIT : IDLE)
                : state_q == WAIT ? (MemReadyM ? IDLE : hang ? ERR : WAIT) : ERR;
    tcnt_d      = state_q == WAIT ? tcnt_q + 16'd1 : 16'd0;
    MemReqValid = !rst && (state_q == IDLE ? MemReqM : state_q == WAIT);
    StallF      = !rst && (freeze || lu);
    StallD      = !rst && (freeze || lu);
    StallE      = !rst && freeze;
    StallM      = !rst && freeze;
    FlushD      = !rst && br;
    FlushE      = !rst && (br || lu);
    FlushW      = !rst && freeze;
  end
  // State, timeout counter, sticky flag and saturating stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tcnt_q      <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      timeout_q   <= timeout_q || hang;
      stall_cnt_q <= StallF && !(&stall_cnt_q) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end
  end
  assign MemTimeout  = timeout_q;
  assign StallCycles = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: randomized and directed checks against a behavioural model
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, MemReqM = 1'b0, MemReadyM = 1'b0, PCSrcE = 1'b0;
  logic [1:0] ResultSrcE = '0;
  logic [4:0] rdE = '0, rs1D = '0, rs2D = '0;
  logic MemReqValid, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [15:0] StallCycles;
  logic b_valid, b_sf, b_sd, b_se, b_sm, b_fd, b_fe, b_fw, b_to;
  logic [3:0] b_cnt;
  int n_cmp = 0, n_bad = 0;

  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .MemReqValid(MemReqValid),
    .ResultSrcE(ResultSrcE), .rdE(rdE), .rs1D(rs1D), .rs2D(rs2D), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .MemTimeout(MemTimeout), .StallCycles(StallCycles)
  );
  pipeline_hazard_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .MemReqM(MemReqM), .MemReadyM(MemReadyM), .MemReqValid(b_valid),
    .ResultSrcE(ResultSrcE), .rdE(rdE), .rs1D(rs1D), .rs2D(rs2D), .PCSrcE(PCSrcE),
    .StallF(b_sf), .StallD(b_sd), .StallE(b_se), .StallM(b_sm),
    .FlushD(b_fd), .FlushE(b_fe), .FlushW(b_fw), .MemTimeout(b_to), .StallCycles(b_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a pending miss counts wait cycles; eight consecutive unanswered wait cycles hang it
  bit m_wait, m_hung, started;
  int m_waited, m_sc, m_sc4;
  bit fr, lu, br;
  logic [8:0] e;
  always @(negedge clk) begin
    if (rst) started = 1'b1;
    if (started) begin
      fr = m_hung || m_wait || (MemReqM && !MemReadyM);
      lu = !fr && !PCSrcE && ResultSrcE == 2'b01 && rdE != 0 && (rdE == rs1D || rdE == rs2D);
      br = !fr && PCSrcE;
      e = rst ? {8'h00, m_hung}
              : {!m_hung && (m_wait || MemReqM), fr || lu, fr || lu, fr, fr, br, br || lu, fr, m_hung};
      chk("ctrl", {23'd0, MemReqValid, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout}, {23'd0, e});
      chk("stall_cycles", {16'd0, StallCycles}, m_sc);
      chk("stall_cycles_w4", {28'd0, b_cnt}, m_sc4);
      if (rst) begin
        m_wait = 0; m_hung = 0; m_waited = 0; m_sc = 0; m_sc4 = 0;
      end else begin
        if (e[7]) begin
          if (m_sc < 65535) m_sc++;
          if (m_sc4 < 15) m_sc4++;
        end
        if (!m_hung) begin
          if (m_wait) begin
            m_waited++;
            if (MemReadyM) m_wait = 0;
            else if (m_waited == 8) begin m_hung = 1; m_wait = 0; end
          end else if (MemReqM && !MemReadyM) begin
            m_wait = 1; m_waited = 0;
          end
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit req, input bit rdy, input logic [1:0] rs,
                     input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b, input bit pc);
    @(posedge clk);
    #1;
    rst = r; MemReqM = req; MemReadyM = rdy; ResultSrcE = rs; rdE = rd; rs1D = a; rs2D = b; PCSrcE = pc;
  endtask

  task automatic look;
    @(negedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    look; chk("reset_outputs", {MemReqValid, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 0);
    cyc(0, 0, 0, 1, 5, 5, 9, 0);
    look; chk("load_use", {StallF, StallD, FlushE, StallE, FlushD}, 5'b11100);
    chk("reset_counter", StallCycles, 0);
    cyc(0, 0, 0, 1, 0, 0, 0, 0);
    look; chk("rd_zero_no_stall", {StallF, FlushE}, 0);
    chk("counter_after_lu", StallCycles, 1);
    cyc(0, 0, 0, 1, 5, 5, 9, 1);
    look; chk("branch_over_lu", {StallF, StallD, FlushD, FlushE}, 4'b0011);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, i == 3, 0, 0, 0, 0, 0);
      look; chk("mem_wait", {MemReqValid, StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE}, 8'hfc);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    look; chk("after_wait_idle", {MemReqValid, StallF, FlushW}, 0);
    chk("wait_count", StallCycles, 4);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 20; i++) begin
      cyc(0, 1, 0, 1, 5, 5, 5, 0);
      look;
      if (i == 8) chk("no_timeout_yet", MemTimeout, 0);
      if (i == 9) chk("err_state", {MemTimeout, MemReqValid, StallF, StallM, FlushW, FlushE}, 6'b101110);
      if (i == 20) begin
        chk("err_count", StallCycles, 20);
        chk("saturate_w4", b_cnt, 15);
      end
    end
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    look; chk("rst_in_err", {MemReqValid, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    look; chk("after_err_reset", {MemTimeout, StallF, FlushW}, 0);
    chk("after_err_count", StallCycles, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    look; chk("mid_wait_reset", {MemReqValid, StallF, StallE, FlushW, MemTimeout}, 0);
    chk("mid_wait_count", StallCycles, 0);
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      rdy_pct = (i / 200) % 2 ? 5 : 60;
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 99) < rdy_pct,
          2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), $urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
